fft_result_streamer: RTL and testbench

- Downstream of the FFT core; upstream of the UART TX path in uart_controller.
- Snapshots one complete FFT result frame (8, 16 or 32 complex bins) on the core's valid strobe.
- Streams the bins one at a time, in ascending bin order, over a valid/ready handshake as R/I coefficient pairs.
- Frees the FFT core to start the next transform while transmission is in progress.

---
 rtl/fft_result_streamer.sv | 211 +++++++++++++++++++++
 tb/tb_fft_result_streamer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_result_streamer.sv
// ---------------------------------------------------------------------------
// fft_result_streamer
//
// Purpose:
//   Sits between the FFT core and the UART TX path. When the core strobes
//   fft_valid_i, the whole result frame (8, 16 or 32 complex bins) is copied
//   into a local buffer. The bins are then handed out one at a time, lowest
//   bin first, over a valid/ready handshake. Because the frame is held
//   locally, the FFT core can start its next transform during transmission.
//
// Ports:
//   clk           in   clock
//   rst           in   synchronous, active-high reset
//   fft_valid_i   in   one-cycle strobe: x_r_i / x_i_i hold a valid frame
//   fft_select_i  in   frame length, sampled with fft_valid_i
//                      (00 = 8, 01 = 16, 10 / 11 = 32)
//   x_r_i         in   real bins, bin k at [k*DATA_W +: DATA_W]
//   x_i_i         in   imaginary bins, same packing
//   coef_r_o      out  real part of the current bin
//   coef_i_o      out  imaginary part of the current bin
//   coef_idx_o    out  index of the current bin
//   coef_valid_o  out  current bin is valid
//   coef_ready_i  in   consumer accepts the current bin
//   tx_start_o    out  one-cycle pulse when a frame starts streaming
//   frame_done_o  out  one-cycle pulse after the last bin is accepted
//   busy_o        out  high while streaming or finishing a frame
//   overrun_o     out  one-cycle pulse when an incoming frame is dropped
// ---------------------------------------------------------------------------
module fft_result_streamer #(
  parameter int N_MAX  = 32,
  parameter int DATA_W = 16,
  parameter int IDX_W  = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fft_valid_i,
  input  logic [1:0]              fft_select_i,
  input  logic [N_MAX*DATA_W-1:0] x_r_i,
  input  logic [N_MAX*DATA_W-1:0] x_i_i,
  output logic [DATA_W-1:0]       coef_r_o,
  output logic [DATA_W-1:0]       coef_i_o,
  output logic [IDX_W-1:0]        coef_idx_o,
  output logic                    coef_valid_o,
  input  logic                    coef_ready_i,
  output logic                    tx_start_o,
  output logic                    frame_done_o,
  output logic                    busy_o,
  output logic                    overrun_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  state_e state_q, state_d;

  // idx_q doubles as the visible bin index; last_idx_q holds len-1 so the
  // end-of-frame test is a plain equality compare and the index never wraps.
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  last_idx_q, last_idx_d;

  logic [DATA_W-1:0] coef_r_q, coef_r_d;
  logic [DATA_W-1:0] coef_i_q, coef_i_d;
  logic              coef_valid_q, coef_valid_d;
  logic              tx_start_q, tx_start_d;
  logic              frame_done_q, frame_done_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;

  // Frame snapshot. Contents are only meaningful after a capture, so the
  // storage carries no reset.
  logic [DATA_W-1:0] buf_r_q [N_MAX];
  logic [DATA_W-1:0] buf_r_d [N_MAX];
  logic [DATA_W-1:0] buf_i_q [N_MAX];
  logic [DATA_W-1:0] buf_i_d [N_MAX];

  logic              transfer;
  logic              last_bin;
  logic [IDX_W-1:0]  next_idx;
  logic [IDX_W-1:0]  sel_last_idx;

  assign transfer = coef_valid_q && coef_ready_i;
  assign last_bin = (idx_q == last_idx_q);
  assign next_idx = idx_q + 1'b1;

  // Decode the frame length into its last valid index. Both 10 and 11 mean
  // a full-size frame.
  always_comb begin
    sel_last_idx = IDX_W'(N_MAX - 1);
    case (fft_select_i)
      2'b00:   sel_last_idx = IDX_W'(7);
      2'b01:   sel_last_idx = IDX_W'(15);
      default: sel_last_idx = IDX_W'(N_MAX - 1);
    endcase
  end

  // Next-state and next-output logic. Output data is registered: when a
  // frame is captured, bin 0 is taken straight from the input bus (the buffer
  // only holds it from the next cycle on); on each accepted bin the following
  // bin is read from the buffer so it appears the very next cycle with no
  // bubble. A stalled bin simply keeps its registers unchanged.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    last_idx_d   = last_idx_q;
    coef_r_d     = coef_r_q;
    coef_i_d     = coef_i_q;
    coef_valid_d = coef_valid_q;
    tx_start_d   = 1'b0;
    frame_done_d = 1'b0;
    buf_r_d      = buf_r_q;
    buf_i_d      = buf_i_q;

    // Any strobe that arrives while a frame is still owned is dropped.
    overrun_d    = fft_valid_i && (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (fft_valid_i) begin
          for (int k = 0; k < N_MAX; k++) begin
            buf_r_d[k] = x_r_i[k*DATA_W +: DATA_W];
            buf_i_d[k] = x_i_i[k*DATA_W +: DATA_W];
          end
          last_idx_d   = sel_last_idx;
          idx_d        = '0;
          coef_r_d     = x_r_i[DATA_W-1:0];
          coef_i_d     = x_i_i[DATA_W-1:0];
          coef_valid_d = 1'b1;
          tx_start_d   = 1'b1;
          state_d      = ST_STREAM;
        end
      end

      ST_STREAM: begin
        if (transfer) begin
          if (last_bin) begin
            // Clear the data outputs too, so idle looks the same as reset.
            idx_d        = '0;
            coef_r_d     = '0;
            coef_i_d     = '0;
            coef_valid_d = 1'b0;
            frame_done_d = 1'b1;
            state_d      = ST_DONE;
          end else begin
            idx_d    = next_idx;
            coef_r_d = buf_r_q[next_idx];
            coef_i_d = buf_i_q[next_idx];
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d      = ST_IDLE;
        idx_d        = '0;
        coef_valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // Control state and registered outputs. Reset returns to an idle, silent
  // streamer with a full-size default length; any frame in flight is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      last_idx_q   <= IDX_W'(N_MAX - 1);
      coef_r_q     <= '0;
      coef_i_q     <= '0;
      coef_valid_q <= 1'b0;
      tx_start_q   <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      last_idx_q   <= last_idx_d;
      coef_r_q     <= coef_r_d;
      coef_i_q     <= coef_i_d;
      coef_valid_q <= coef_valid_d;
      tx_start_q   <= tx_start_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
    end
  end

  // Frame buffer storage, loaded only on a capture.
  always_ff @(posedge clk) begin
    buf_r_q <= buf_r_d;
    buf_i_q <= buf_i_d;
  end

  assign coef_r_o     = coef_r_q;
  assign coef_i_o     = coef_i_q;
  assign coef_idx_o   = idx_q;
  assign coef_valid_o = coef_valid_q;
  assign tx_start_o   = tx_start_q;
  assign frame_done_o = frame_done_q;
  assign busy_o       = busy_q;
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_fft_result_streamer.sv
// ---------------------------------------------------------------------------
// tb_fft_result_streamer
//
// Self-checking bench for fft_result_streamer. A behavioural model tracks the
// frame being sent as a simple position within a copied frame: -1 when idle,
// 0..len-1 while a bin is on offer, len during the completion cycle. Each
// cycle the DUT outputs are compared with what that position implies.
// ---------------------------------------------------------------------------
module tb_fft_result_streamer;

  localparam int N_MAX  = 32;
  localparam int DATA_W = 16;
  localparam int IDX_W  = 5;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    fft_valid_i;
  logic [1:0]              fft_select_i;
  logic [N_MAX*DATA_W-1:0] x_r_i;
  logic [N_MAX*DATA_W-1:0] x_i_i;
  logic [DATA_W-1:0]       coef_r_o;
  logic [DATA_W-1:0]       coef_i_o;
  logic [IDX_W-1:0]        coef_idx_o;
  logic                    coef_valid_o;
  logic                    coef_ready_i;
  logic                    tx_start_o;
  logic                    frame_done_o;
  logic                    busy_o;
  logic                    overrun_o;

  fft_result_streamer #(
    .N_MAX (N_MAX),
    .DATA_W(DATA_W),
    .IDX_W (IDX_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fft_valid_i (fft_valid_i),
    .fft_select_i(fft_select_i),
    .x_r_i       (x_r_i),
    .x_i_i       (x_i_i),
    .coef_r_o    (coef_r_o),
    .coef_i_o    (coef_i_o),
    .coef_idx_o  (coef_idx_o),
    .coef_valid_o(coef_valid_o),
    .coef_ready_i(coef_ready_i),
    .tx_start_o  (tx_start_o),
    .frame_done_o(frame_done_o),
    .busy_o      (busy_o),
    .overrun_o   (overrun_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int              m_pos = -1;
  int              m_len = 32;
  logic [DATA_W-1:0] m_r [N_MAX];
  logic [DATA_W-1:0] m_i [N_MAX];
  logic            m_tx  = 1'b0;
  logic            m_ovr = 1'b0;

  // Observed event counters
  int   dut_xfers  = 0;
  int   dut_dones  = 0;
  int   dut_ovrs   = 0;
  logic prev_valid = 1'b0;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model update on a clock edge, using the inputs held for that cycle.
  task automatic modelUpdate();
    m_tx  = 1'b0;
    m_ovr = 1'b0;
    if (rst) begin
      m_pos = -1;
    end else if (m_pos < 0) begin
      if (fft_valid_i) begin
        for (int k = 0; k < N_MAX; k++) begin
          m_r[k] = x_r_i[k*DATA_W +: DATA_W];
          m_i[k] = x_i_i[k*DATA_W +: DATA_W];
        end
        m_len = (fft_select_i == 2'b00) ? 8 : (fft_select_i == 2'b01) ? 16 : 32;
        m_pos = 0;
        m_tx  = 1'b1;
      end
    end else begin
      if (fft_valid_i) m_ovr = 1'b1;
      if (m_pos == m_len) m_pos = -1;
      else if (coef_ready_i) m_pos = m_pos + 1;
    end
  endtask

  // Compare every output with what the model position implies.
  task automatic compareAll();
    logic exp_valid;
    exp_valid = (m_pos >= 0) && (m_pos < m_len);
    checkOutput("coef_valid", coef_valid_o, exp_valid);
    checkOutput("tx_start", tx_start_o, m_tx);
    checkOutput("frame_done", frame_done_o, (m_pos >= 0) && (m_pos == m_len));
    checkOutput("busy", busy_o, m_pos >= 0);
    checkOutput("overrun", overrun_o, m_ovr);
    if (exp_valid) begin
      checkOutput("coef_idx", coef_idx_o, m_pos);
      checkOutput("coef_r", coef_r_o, m_r[m_pos]);
      checkOutput("coef_i", coef_i_o, m_i[m_pos]);
    end
    if (frame_done_o) dut_dones++;
    if (overrun_o) dut_ovrs++;
    prev_valid = coef_valid_o;
  endtask

  // Drive one cycle of inputs, advance a clock, then check outputs.
  task automatic applyStimulus(input logic r, input logic v, input logic [1:0] sel, input logic rdy);
    rst          = r;
    fft_valid_i  = v;
    fft_select_i = sel;
    coef_ready_i = rdy;
    @(posedge clk);
    if (prev_valid && rdy && !r) dut_xfers++;
    modelUpdate();
    @(negedge clk);
    compareAll();
  endtask

  // Load the input buses with a counting pattern or random data.
  task automatic setFrame(input logic [DATA_W-1:0] base_r, input logic [DATA_W-1:0] base_i, input bit rnd);
    for (int k = 0; k < N_MAX; k++) begin
      x_r_i[k*DATA_W +: DATA_W] = rnd ? DATA_W'($urandom) : base_r + DATA_W'(k);
      x_i_i[k*DATA_W +: DATA_W] = rnd ? DATA_W'($urandom) : base_i + DATA_W'(k);
    end
  endtask

  // Run until the model is idle. mode 0: ready high; 1: 1,0,0 pattern;
  // 2: random ready with occasional stray strobes.
  task automatic runUntilIdle(input int mode, input int budget);
    int   ph;
    logic rdy;
    logic v;
    ph = 0;
    for (int n = 0; n < budget && m_pos >= 0; n++) begin
      v = 1'b0;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (ph % 3 == 0);
        default: begin
          rdy = ($urandom_range(0, 9) < 7);
          v   = ($urandom_range(0, 7) == 0);
        end
      endcase
      ph++;
      applyStimulus(1'b0, v, fft_select_i, rdy);
    end
    checkOutput("idle_busy", busy_o, 1'b0);
  endtask

  task automatic clearCounts();
    dut_xfers = 0;
    dut_dones = 0;
    dut_ovrs  = 0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog timeout at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst          = 1'b1;
    fft_valid_i  = 1'b0;
    fft_select_i = 2'b00;
    coef_ready_i = 1'b0;
    setFrame(16'h0, 16'h0, 1'b1);

    // Reset for three cycles; everything must be quiet.
    for (int n = 0; n < 3; n++) applyStimulus(1'b1, 1'b0, 2'b00, 1'b0);
    checkOutput("rst_coef_r", coef_r_o, 0);
    checkOutput("rst_coef_i", coef_i_o, 0);
    checkOutput("rst_coef_idx", coef_idx_o, 0);
    checkOutput("rst_valid", coef_valid_o, 0);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_done", frame_done_o, 0);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0);

    // 8-point counting frame, ready held high.
    $display("[TB] 8-point frame");
    clearCounts();
    setFrame(16'h1000, 16'h2000, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'b00, 1'b1);
    checkOutput("p8_tx_start", tx_start_o, 1);
    checkOutput("p8_first_r", coef_r_o, 16'h1000);
    runUntilIdle(0, 40);
    checkOutput("p8_xfers", dut_xfers, 8);
    checkOutput("p8_dones", dut_dones, 1);

    // 32-point frame with ready toggling 1,0,0.
    $display("[TB] backpressure 32-point");
    clearCounts();
    setFrame(16'h0, 16'h0, 1'b1);
    applyStimulus(1'b0, 1'b1, 2'b10, 1'b0);
    runUntilIdle(1, 200);
    checkOutput("bp_xfers", dut_xfers, 32);
    checkOutput("bp_dones", dut_dones, 1);

    // Overrun during a 16-point frame, then a back-to-back capture.
    $display("[TB] overrun");
    clearCounts();
    setFrame(16'h3000, 16'h4000, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'b01, 1'b1);
    for (int n = 0; n < 20 && m_pos != 3; n++) applyStimulus(1'b0, 1'b0, 2'b01, 1'b1);
    setFrame(16'h0, 16'h0, 1'b1);
    x_r_i[DATA_W-1:0] = 16'hBEEF;
    applyStimulus(1'b0, 1'b1, 2'b01, 1'b1);
    checkOutput("ovr_pulse", overrun_o, 1);
    runUntilIdle(0, 60);
    checkOutput("ovr_count", dut_ovrs, 1);
    checkOutput("ovr_xfers", dut_xfers, 16);
    clearCounts();
    applyStimulus(1'b0, 1'b1, 2'b00, 1'b1);
    checkOutput("ovr_recap_tx", tx_start_o, 1);
    checkOutput("ovr_recap_r", coef_r_o, 16'hBEEF);
    runUntilIdle(0, 40);
    checkOutput("ovr_recap_xfers", dut_xfers, 8);

    // Reset at idx 5 of a 16-point frame; a strobe during reset is lost.
    $display("[TB] reset mid-stream");
    clearCounts();
    setFrame(16'h5000, 16'h6000, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'b01, 1'b1);
    for (int n = 0; n < 20 && m_pos != 5; n++) applyStimulus(1'b0, 1'b0, 2'b01, 1'b1);
    applyStimulus(1'b1, 1'b1, 2'b00, 1'b1);
    checkOutput("mid_rst_valid", coef_valid_o, 0);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b1);
    checkOutput("mid_rst_dones", dut_dones, 0);
    clearCounts();
    setFrame(16'h0, 16'h0, 1'b1);
    applyStimulus(1'b0, 1'b1, 2'b00, 1'b1);
    runUntilIdle(0, 40);
    checkOutput("mid_rst_xfers", dut_xfers, 8);

    // Select 11 with ready low for 10 cycles.
    $display("[TB] select 11 with initial stall");
    clearCounts();
    setFrame(16'h0, 16'h0, 1'b1);
    applyStimulus(1'b0, 1'b1, 2'b11, 1'b0);
    for (int n = 0; n < 10; n++) applyStimulus(1'b0, 1'b0, 2'b11, 1'b0);
    checkOutput("s11_hold_idx", coef_idx_o, 0);
    runUntilIdle(0, 60);
    checkOutput("s11_xfers", dut_xfers, 32);

    // Random frames, random lengths, random ready, stray strobes.
    $display("[TB] random frames");
    for (int f = 0; f < 6; f++) begin
      logic [1:0] sel;
      sel = 2'($urandom_range(0, 3));
      setFrame(16'h0, 16'h0, 1'b1);
      applyStimulus(1'b0, 1'b1, sel, 1'b1);
      runUntilIdle(2, 300);
      applyStimulus(1'b0, 1'b0, sel, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
